// File: rtl/serial_io_bus_bridge_pkg.sv
// serial_io_pkg: shared FSM states, UART offsets, idle bus values and phase limits for the serial IO bridge
package serial_io_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;
  localparam logic [11:0] UART_RS232_OFS = 12'h020;
  localparam logic [11:0] UART_GPS_OFS   = 12'h021;
  localparam logic [11:0] UART_BT_OFS    = 12'h022;
  localparam logic [11:0] UART_TS_OFS    = 12'h023;
  localparam logic [15:0] IDLE_ADDR = 16'h0000;
  localparam logic [15:0] IDLE_DATA = 16'h0000;
  localparam logic        IDLE_BSEL = 1'b1;
  localparam int SETUP_MAX  = 15;
  localparam int STROBE_MAX = 255;
  localparam int HOLD_MAX   = 15;
  // Counter load is phase length minus one, clamped to the legal phase width.
  function automatic logic [7:0] phase_load(input int n, input int max);
    return n > 0 ? 8'((n > max ? max : n) - 1) : 8'd0;
  endfunction
endpackage

// File: rtl/serial_io_bus_bridge_if.sv
// serial_io_bus_bridge_if: Avalon-MM slave side plus serial IO bus side of the bridge
interface serial_io_bus_bridge_if;
  logic [15:0] Avs_Address;
  logic        Avs_Read_H;
  logic        Avs_Write_H;
  logic [7:0]  Avs_WriteData;
  logic [7:0]  Avs_ReadData;
  logic        Avs_WaitRequest_H;
  logic [15:0] Address;
  logic        IOSelect_H;
  logic        ByteSelect_L;
  logic        WriteEnable_L;
  logic        ReadEnable_L;
  logic [15:0] IO_DataOut;
  logic [15:0] IO_DataIn;
  logic        IO_Ready_H;
  logic        Timeout_H;
  modport slave (
    input  Avs_Address, Avs_Read_H, Avs_Write_H, Avs_WriteData, IO_DataIn, IO_Ready_H,
    output Avs_ReadData, Avs_WaitRequest_H, Address, IOSelect_H, ByteSelect_L,
           WriteEnable_L, ReadEnable_L, IO_DataOut, Timeout_H
  );
  modport master (
    output Avs_Address, Avs_Read_H, Avs_Write_H, Avs_WriteData, IO_DataIn, IO_Ready_H,
    input  Avs_ReadData, Avs_WaitRequest_H, Address, IOSelect_H, ByteSelect_L,
           WriteEnable_L, ReadEnable_L, IO_DataOut, Timeout_H
  );
endinterface

// File: rtl/serial_io_phase_counter.sv
// serial_io_phase_counter: 8-bit load/decrement counter that saturates at zero, shared by all bus phases
module serial_io_phase_counter (
  input  logic       Clock,
  input  logic       Reset_L,
  input  logic       ld,
  input  logic [7:0] ld_val,
  output logic       zero
);
  logic [7:0] cnt;
  always_ff @(posedge Clock or negedge Reset_L)
    if (!Reset_L) cnt <= 8'd0;
    else cnt <= ld ? ld_val : (cnt != 8'd0 ? cnt - 8'd1 : cnt);
  assign zero = cnt == 8'd0;
endmodule

// File: rtl/serial_io_bus_bridge.sv
// serial_io_bus_bridge: stretches one Avalon access into setup/strobe/hold on the serial IO bus.
// Define SERIALIO_TIMEOUT_EN to abort stuck strobes after TIMEOUT_CYCLES.
module serial_io_bus_bridge
  import serial_io_pkg::*;
#(
  parameter int SETUP_CYCLES   = 1,
  parameter int STROBE_CYCLES  = 4,
  parameter int HOLD_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic Clock,
  input logic Reset_L,
  serial_io_bus_bridge_if.slave bus
);
  localparam logic [7:0] setup_ld  = phase_load(SETUP_CYCLES, SETUP_MAX);
  localparam logic [7:0] strobe_ld = phase_load(STROBE_CYCLES, STROBE_MAX);
  localparam logic [7:0] hold_ld   = phase_load(HOLD_CYCLES, HOLD_MAX);
  state_t state, state_nxt;
  logic [15:0] addr_q;
  logic [7:0] data_q, rd_q, ld_val;
  logic wr_q, ld, zero, tmo, strobe_done, active;
  wire req = bus.Avs_Read_H | bus.Avs_Write_H;
  serial_io_phase_counter u_cnt (.Clock(Clock), .Reset_L(Reset_L), .ld(ld), .ld_val(ld_val), .zero(zero));
`ifdef SERIALIO_TIMEOUT_EN
  logic [10:0] tcnt;
  logic tmo_q;
  always_ff @(posedge Clock or negedge Reset_L)
    if (!Reset_L) begin
      tcnt  <= 11'd0;
      tmo_q <= 1'b0;
    end else begin
      tcnt <= state == STROBE ? tcnt + 11'd1 : 11'd0;
      if (state == STROBE && tmo) tmo_q <= 1'b1;
    end
  assign tmo = tcnt == 11'(TIMEOUT_CYCLES - 1) && !bus.IO_Ready_H;
  assign bus.Timeout_H = tmo_q;
`else
  assign tmo = 1'b0;
  assign bus.Timeout_H = 1'b0;
`endif
  assign strobe_done = (zero && bus.IO_Ready_H) || tmo;
  always_ff @(posedge Clock or negedge Reset_L)
    if (!Reset_L) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    ld = 1'b0;
    ld_val = 8'd0;
    case (state)
      IDLE: if (req) begin
        state_nxt = SETUP_CYCLES > 0 ? SETUP : STROBE;
        ld = 1'b1;
        ld_val = SETUP_CYCLES > 0 ? setup_ld : strobe_ld;
      end
      SETUP: if (zero) begin
        state_nxt = STROBE;
        ld = 1'b1;
        ld_val = strobe_ld;
      end
      STROBE: if (strobe_done) begin
        state_nxt = HOLD_CYCLES > 0 ? HOLD : DONE;
        ld = 1'b1;
        ld_val = hold_ld;
      end
      HOLD: if (zero) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // Simultaneous read and write latch as a write.
  always_ff @(posedge Clock or negedge Reset_L)
    if (!Reset_L) begin
      addr_q <= 16'h0000;
      wr_q   <= 1'b0;
      data_q <= 8'h00;
      rd_q   <= 8'h00;
    end else begin
      if (state == IDLE && req) begin
        addr_q <= bus.Avs_Address;
        wr_q   <= bus.Avs_Write_H;
        data_q <= bus.Avs_WriteData;
      end
      if (state == STROBE && strobe_done && !wr_q)
        rd_q <= tmo ? 8'hFF : (addr_q[0] ? bus.IO_DataIn[7:0] : bus.IO_DataIn[15:8]);
    end
  assign active = state == SETUP || state == STROBE || state == HOLD;
  assign bus.Address = active ? addr_q : IDLE_ADDR;
  assign bus.IOSelect_H = active;
  assign bus.ByteSelect_L = active ? addr_q[0] : IDLE_BSEL;
  assign bus.IO_DataOut = active ? (addr_q[0] ? {8'h00, data_q} : {data_q, 8'h00}) : IDLE_DATA;
  assign bus.WriteEnable_L = !(state == STROBE && wr_q);
  assign bus.ReadEnable_L = !(state == STROBE && !wr_q);
  assign bus.Avs_ReadData = rd_q;
  assign bus.Avs_WaitRequest_H = state != DONE;
endmodule

// File: tb/tb_serial_io_bus_bridge.sv
// tb_serial_io_bus_bridge: scoreboard-driven bench for serial_io_bus_bridge at default timing parameters
module tb_serial_io_bus_bridge;
  typedef struct {
    logic [15:0] addr;
    logic        bsel;
    logic [15:0] dout;
    int          we;
    int          re;
    int          sel;
    int          lat;
    logic [7:0]  rd;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  exp_t sbq[$];
  logic [7:0] last_rd;
  int m_lat, m_sel, m_we, m_re;
  bit m_to, m_stable;
  logic [15:0] m_addr, m_dout;
  logic m_bsel;
  logic [7:0] m_rd;
  always #5 clk = ~clk;
  serial_io_bus_bridge_if bus();
  serial_io_bus_bridge dut (.Clock(clk), .Reset_L(rst_n), .bus(bus));

  task automatic access(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] wd,
                        input logic [15:0] din, input int dly, input bit hold);
    int n = 0;
    int sc = 0;
    bus.Avs_Address = a;
    bus.Avs_Read_H = rd;
    bus.Avs_Write_H = wr;
    bus.Avs_WriteData = wd;
    bus.IO_Ready_H = dly == 0;
    bus.IO_DataIn = dly == 0 ? din : 16'hC3C3;
    m_lat = 0; m_sel = 0; m_we = 0; m_re = 0; m_to = 1; m_stable = 1;
    m_addr = 16'hxxxx; m_dout = 16'hxxxx; m_bsel = 1'bx; m_rd = 8'hxx;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      n++;
      if (bus.IOSelect_H) begin
        if (m_sel == 0) begin
          m_addr = bus.Address; m_bsel = bus.ByteSelect_L; m_dout = bus.IO_DataOut;
        end else if (m_addr !== bus.Address || m_bsel !== bus.ByteSelect_L || m_dout !== bus.IO_DataOut)
          m_stable = 0;
        m_sel++;
      end
      if (!bus.WriteEnable_L) m_we++;
      if (!bus.ReadEnable_L) m_re++;
      if (!bus.WriteEnable_L || !bus.ReadEnable_L) begin
        sc++;
        if (sc > dly) begin
          bus.IO_Ready_H = 1'b1;
          bus.IO_DataIn = din;
        end
      end
      if (!bus.Avs_WaitRequest_H) begin
        m_lat = n; m_rd = bus.Avs_ReadData; m_to = 0;
        break;
      end
    end
    if (!hold) begin
      @(posedge clk); #1;
      bus.Avs_Read_H = 1'b0;
      bus.Avs_Write_H = 1'b0;
    end
  endtask

  task automatic test_reset;
    logic [45:0] v;
    v = {bus.Address, bus.IOSelect_H, bus.ByteSelect_L, bus.WriteEnable_L, bus.ReadEnable_L,
         bus.IO_DataOut, bus.Avs_ReadData, bus.Timeout_H, bus.Avs_WaitRequest_H};
    checks++;
    if (v !== {16'h0000, 4'b0111, 16'h0000, 8'h00, 2'b01}) begin
      errors++; $display("FAIL reset_outputs got %h exp %h", v, {16'h0000, 4'b0111, 16'h0000, 8'h00, 2'b01});
    end
  endtask

  task automatic test_write;
    exp_t e;
    sbq.push_back('{addr: 16'h0200, bsel: 1'b0, dout: 16'h5500, we: 4, re: 0, sel: 6, lat: 7, rd: last_rd});
    access(1'b0, 1'b1, 16'h0200, 8'h55, 16'h0000, 0, 1'b0);
    e = sbq.pop_front();
    checks++; if (m_to) begin errors++; $display("FAIL write_timeout got none exp waitrequest low"); end
    checks++; if (m_lat !== e.lat) begin errors++; $display("FAIL write_latency got %0d exp %0d", m_lat, e.lat); end
    checks++; if (m_sel !== e.sel || !m_stable) begin errors++; $display("FAIL write_select got %0d stable %0d exp %0d", m_sel, m_stable, e.sel); end
    checks++; if (m_addr !== e.addr) begin errors++; $display("FAIL write_addr got %h exp %h", m_addr, e.addr); end
    checks++; if (m_bsel !== e.bsel) begin errors++; $display("FAIL write_bsel got %b exp %b", m_bsel, e.bsel); end
    checks++; if (m_dout !== e.dout) begin errors++; $display("FAIL write_dout got %h exp %h", m_dout, e.dout); end
    checks++; if (m_we !== e.we || m_re !== e.re) begin errors++; $display("FAIL write_strobe got we %0d re %0d exp we %0d re %0d", m_we, m_re, e.we, e.re); end
    checks++; if (m_rd !== e.rd) begin errors++; $display("FAIL write_rdata got %h exp %h", m_rd, e.rd); end
  endtask

  task automatic test_read;
    exp_t e;
    sbq.push_back('{addr: 16'h0211, bsel: 1'b1, dout: 16'h0000, we: 0, re: 4, sel: 6, lat: 7, rd: 8'hAB});
    access(1'b1, 1'b0, 16'h0211, 8'h00, 16'h12AB, 0, 1'b0);
    e = sbq.pop_front();
    last_rd = e.rd;
    checks++; if (m_lat !== e.lat) begin errors++; $display("FAIL read_latency got %0d exp %0d", m_lat, e.lat); end
    checks++; if (m_addr !== e.addr || m_bsel !== e.bsel) begin errors++; $display("FAIL read_addr got %h/%b exp %h/%b", m_addr, m_bsel, e.addr, e.bsel); end
    checks++; if (m_re !== e.re || m_we !== e.we) begin errors++; $display("FAIL read_strobe got re %0d we %0d exp re %0d we %0d", m_re, m_we, e.re, e.we); end
    checks++; if (m_rd !== e.rd) begin errors++; $display("FAIL read_data got %h exp %h", m_rd, e.rd); end
  endtask

  task automatic test_ready_wait;
    exp_t e;
    sbq.push_back('{addr: 16'h0230, bsel: 1'b0, dout: 16'h0000, we: 0, re: 11, sel: 13, lat: 14, rd: 8'h3C});
    access(1'b1, 1'b0, 16'h0230, 8'h00, 16'h3C77, 10, 1'b0);
    e = sbq.pop_front();
    last_rd = e.rd;
    checks++; if (m_re !== e.re) begin errors++; $display("FAIL wait_strobe got %0d exp %0d", m_re, e.re); end
    checks++; if (m_lat !== e.lat) begin errors++; $display("FAIL wait_latency got %0d exp %0d", m_lat, e.lat); end
    checks++; if (m_sel !== e.sel || !m_stable) begin errors++; $display("FAIL wait_select got %0d stable %0d exp %0d", m_sel, m_stable, e.sel); end
    checks++; if (m_rd !== e.rd) begin errors++; $display("FAIL wait_data got %h exp %h", m_rd, e.rd); end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    logic [45:0] v;
    bus.Avs_Address = 16'h0212; bus.Avs_Read_H = 1'b1; bus.IO_Ready_H = 1'b0;
    for (int i = 0; i < 20 && bus.ReadEnable_L; i++) begin @(posedge clk); #1; end
    checks++; if (bus.ReadEnable_L !== 1'b0) begin errors++; $display("FAIL midrst_strobe got %b exp 0", bus.ReadEnable_L); end
    @(posedge clk); #3;
    rst_n = 1'b0;
    bus.Avs_Read_H = 1'b0;
    #1;
    v = {bus.Address, bus.IOSelect_H, bus.ByteSelect_L, bus.WriteEnable_L, bus.ReadEnable_L,
         bus.IO_DataOut, bus.Avs_ReadData, bus.Timeout_H, bus.Avs_WaitRequest_H};
    checks++;
    if (v !== {16'h0000, 4'b0111, 16'h0000, 8'h00, 2'b01}) begin
      errors++; $display("FAIL midrst_idle got %h exp %h", v, {16'h0000, 4'b0111, 16'h0000, 8'h00, 2'b01});
    end
    #2 rst_n = 1'b1;
    last_rd = 8'h00;
    @(negedge clk);
    sbq.push_back('{addr: 16'h0201, bsel: 1'b1, dout: 16'h003A, we: 4, re: 0, sel: 6, lat: 7, rd: 8'h00});
    access(1'b0, 1'b1, 16'h0201, 8'h3A, 16'h0000, 0, 1'b0);
    e = sbq.pop_front();
    checks++; if (m_lat !== e.lat || m_sel !== e.sel) begin errors++; $display("FAIL midrst_fresh got lat %0d sel %0d exp %0d %0d", m_lat, m_sel, e.lat, e.sel); end
    checks++; if (m_dout !== e.dout || m_bsel !== e.bsel) begin errors++; $display("FAIL midrst_dout got %h/%b exp %h/%b", m_dout, m_bsel, e.dout, e.bsel); end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    sbq.push_back('{addr: 16'h0220, bsel: 1'b0, dout: 16'hA500, we: 4, re: 0, sel: 6, lat: 7, rd: last_rd});
    sbq.push_back('{addr: 16'h0221, bsel: 1'b1, dout: 16'h005A, we: 4, re: 0, sel: 6, lat: 7, rd: last_rd});
    access(1'b1, 1'b1, 16'h0220, 8'hA5, 16'h9999, 0, 1'b1);
    e = sbq.pop_front();
    checks++; if (m_we !== e.we || m_re !== e.re) begin errors++; $display("FAIL both_strobe got we %0d re %0d exp we %0d re %0d", m_we, m_re, e.we, e.re); end
    checks++; if (m_dout !== e.dout || m_rd !== e.rd) begin errors++; $display("FAIL both_data got %h/%h exp %h/%h", m_dout, m_rd, e.dout, e.rd); end
    @(posedge clk); #1;
    checks++; if (bus.IOSelect_H !== 1'b0 || bus.Avs_WaitRequest_H !== 1'b1) begin errors++; $display("FAIL b2b_idle got sel %b wr %b exp 0 1", bus.IOSelect_H, bus.Avs_WaitRequest_H); end
    access(1'b0, 1'b1, 16'h0221, 8'h5A, 16'h0000, 0, 1'b0);
    e = sbq.pop_front();
    checks++; if (m_lat !== e.lat || m_addr !== e.addr) begin errors++; $display("FAIL b2b_second got lat %0d addr %h exp %0d %h", m_lat, m_addr, e.lat, e.addr); end
    checks++; if (m_dout !== e.dout) begin errors++; $display("FAIL b2b_dout got %h exp %h", m_dout, e.dout); end
  endtask

`ifdef SERIALIO_TIMEOUT_EN
  task automatic test_timeout;
    exp_t e;
    sbq.push_back('{addr: 16'h0222, bsel: 1'b0, dout: 16'h0000, we: 0, re: 1024, sel: 1026, lat: 1027, rd: 8'hFF});
    access(1'b1, 1'b0, 16'h0222, 8'h00, 16'h1111, 5000, 1'b0);
    e = sbq.pop_front();
    bus.IO_Ready_H = 1'b1;
    checks++; if (m_re !== e.re || m_lat !== e.lat) begin errors++; $display("FAIL tmo_strobe got re %0d lat %0d exp %0d %0d", m_re, m_lat, e.re, e.lat); end
    checks++; if (m_rd !== e.rd) begin errors++; $display("FAIL tmo_data got %h exp %h", m_rd, e.rd); end
    checks++; if (bus.Timeout_H !== 1'b1) begin errors++; $display("FAIL tmo_flag got %b exp 1", bus.Timeout_H); end
    access(1'b0, 1'b1, 16'h0200, 8'h01, 16'h0000, 0, 1'b0);
    checks++; if (bus.Timeout_H !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %b exp 1", bus.Timeout_H); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    bus.Avs_Address = 16'h0000; bus.Avs_Read_H = 1'b0; bus.Avs_Write_H = 1'b0;
    bus.Avs_WriteData = 8'h00; bus.IO_DataIn = 16'h0000; bus.IO_Ready_H = 1'b1;
    last_rd = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_write;
    test_read;
    test_ready_wait;
    test_reset_mid;
    test_back_to_back;
`ifdef SERIALIO_TIMEOUT_EN
    test_timeout;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
